// File: rtl/example_seq_arb_if.sv
// Requester command channels and datapath drive of the shared example datapath.
// The arbiter takes the slave side; requesters and the datapath sit on the master side.
interface example_seq_arb_if #(
   parameter int LEN_W = 3
);
   logic             req0_valid;
   logic [1:0]       req0_ab;
   logic [LEN_W-1:0] req0_len;
   logic             req0_ready;
   logic             req1_valid;
   logic [1:0]       req1_ab;
   logic [LEN_W-1:0] req1_len;
   logic             req1_ready;
   logic             a;
   logic             b;
   logic             busy;
   logic             owner;
   logic             done;
   logic             done_id;

   modport slave (
      input  req0_valid, req0_ab, req0_len,
      input  req1_valid, req1_ab, req1_len,
      output req0_ready, req1_ready,
      output a, b, busy, owner, done, done_id
   );

   modport master (
      output req0_valid, req0_ab, req0_len,
      output req1_valid, req1_ab, req1_len,
      input  req0_ready, req1_ready,
      input  a, b, busy, owner, done, done_id
   );
endinterface

// File: rtl/example_seq_arb.sv
// Round-robin arbiter/sequencer sharing the example datapath (a, b) between two requesters.
//
//   state | meaning
//   IDLE  | arbitrate, one requester may handshake
//   RUN   | drive {a,b} for len+1 cycles, cnt counts down to 0
//   GAP   | one idle cycle with a=b=0, done pulse visible
module example_seq_arb #(
   parameter int LEN_W = 3
) (
   input  logic             clk,
   input  logic             rstn,
   example_seq_arb_if.slave bus
);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_GAP  = 2'd2;

   logic [1:0]       state_q,   state_d;
   logic [LEN_W-1:0] cnt_q,     cnt_d;
   logic [1:0]       ab_q,      ab_d;
   logic             busy_q,    busy_d;
   logic             owner_q,   owner_d;
   logic             done_q,    done_d;
   logic             done_id_q, done_id_d;
   logic             last_q,    last_d;

   logic gnt_id;
   logic in_idle;
   logic rdy0;
   logic rdy1;

   // On a tie the requester that did not win last time goes first.
   assign gnt_id  = (bus.req0_valid && bus.req1_valid) ? ~last_q : bus.req1_valid;
   assign in_idle = (state_q == S_IDLE);
   assign rdy0    = in_idle && bus.req0_valid && !gnt_id;
   assign rdy1    = in_idle && bus.req1_valid &&  gnt_id;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      ab_d      = ab_q;
      busy_d    = busy_q;
      owner_d   = owner_q;
      done_d    = done_q;
      done_id_d = done_id_q;
      last_d    = last_q;
      case (state_q)
         S_IDLE: begin
            if (rdy0 || rdy1) begin
               ab_d    = gnt_id ? bus.req1_ab  : bus.req0_ab;
               cnt_d   = gnt_id ? bus.req1_len : bus.req0_len;
               owner_d = gnt_id;
               last_d  = gnt_id;
               busy_d  = 1'b1;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - LEN_W'(1);
            end else begin
               ab_d      = 2'b00;
               done_d    = 1'b1;
               done_id_d = owner_q;
               state_d   = S_GAP;
            end
         end
         S_GAP: begin
            busy_d  = 1'b0;
            done_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: begin
            ab_d    = 2'b00;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         ab_q      <= 2'b00;
         busy_q    <= 1'b0;
         owner_q   <= 1'b0;
         done_q    <= 1'b0;
         done_id_q <= 1'b0;
         last_q    <= 1'b1;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         ab_q      <= ab_d;
         busy_q    <= busy_d;
         owner_q   <= owner_d;
         done_q    <= done_d;
         done_id_q <= done_id_d;
         last_q    <= last_d;
      end
   end

   assign bus.req0_ready = rdy0;
   assign bus.req1_ready = rdy1;
   assign bus.a          = ab_q[1];
   assign bus.b          = ab_q[0];
   assign bus.busy       = busy_q;
   assign bus.owner      = owner_q;
   assign bus.done       = done_q;
   assign bus.done_id    = done_id_q;
endmodule

// File: tb/tb_example_seq_arb.sv
// Bench for example_seq_arb: cycle-indexed transaction model checked every cycle,
// plus directed scenarios with hand-computed counts.
module tb_example_seq_arb;
   localparam int LEN_W = 3;

   logic clk  = 1'b0;
   logic rstn = 1'b1;
   always #5 clk = ~clk;

   example_seq_arb_if #(.LEN_W(LEN_W)) ifc ();

   example_seq_arb #(.LEN_W(LEN_W)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (ifc)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: a command accepted at the end of cycle S with length L is driven
   // in cycles S+1..S+L+1, its gap/done is cycle S+L+2, idle again from S+L+3.
   bit         m_active;
   int         m_now;
   int         m_start;
   int         m_len;
   logic [1:0] m_ab;
   bit         m_id;
   bit         m_last;
   bit         m_owner;
   bit         chk_on = 1'b0;

   function automatic bit m_idle();
      return !m_active || (m_now >= m_start + m_len + 3);
   endfunction

   function automatic bit m_gnt();
      if (ifc.req0_valid && ifc.req1_valid) return !m_last;
      return ifc.req1_valid;
   endfunction

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         m_active <= 1'b0;
         m_now    <= 0;
         m_start  <= 0;
         m_len    <= 0;
         m_ab     <= 2'b00;
         m_id     <= 1'b0;
         m_last   <= 1'b1;
         m_owner  <= 1'b0;
      end else begin
         if (m_idle() && (ifc.req0_valid || ifc.req1_valid)) begin
            m_active <= 1'b1;
            m_start  <= m_now;
            m_id     <= m_gnt();
            m_last   <= m_gnt();
            m_owner  <= m_gnt();
            m_len    <= m_gnt() ? int'(ifc.req1_len) : int'(ifc.req0_len);
            m_ab     <= m_gnt() ? ifc.req1_ab : ifc.req0_ab;
         end
         m_now <= m_now + 1;
      end
   end

   always @(negedge clk) begin
      if (chk_on) begin
         int  k;
         bit  e_run, e_gap;
         k     = m_now - m_start;
         e_run = m_active && (k >= 1) && (k <= m_len + 1);
         e_gap = m_active && (k == m_len + 2);
         chk("ready0", ifc.req0_ready, m_idle() && ifc.req0_valid && !m_gnt());
         chk("ready1", ifc.req1_ready, m_idle() && ifc.req1_valid &&  m_gnt());
         chk("a",      ifc.a,     e_run ? m_ab[1] : 1'b0);
         chk("b",      ifc.b,     e_run ? m_ab[0] : 1'b0);
         chk("busy",   ifc.busy,  e_run || e_gap);
         chk("done",   ifc.done,  e_gap);
         chk("owner",  ifc.owner, m_owner);
         if (e_gap) chk("done_id", ifc.done_id, m_id);
      end
   end

   // Window monitor for the directed scenarios.
   bit mon_en = 1'b0;
   int wcyc, n_r0, n_r1, first_r1, n_ab11, n_ab10, n_ab01, n_busy, n_done, ng, nd;
   bit gseq [8];
   bit dseq [8];

   always @(negedge clk) begin
      if (mon_en) begin
         if (ifc.req0_ready) n_r0 <= n_r0 + 1;
         if (ifc.req1_ready) begin
            n_r1 <= n_r1 + 1;
            if (first_r1 < 0) first_r1 <= wcyc;
         end
         if ((ifc.req0_ready || ifc.req1_ready) && ng < 8) begin
            gseq[ng] <= ifc.req1_ready;
            ng       <= ng + 1;
         end
         if (ifc.a && ifc.b)   n_ab11 <= n_ab11 + 1;
         if (ifc.a && !ifc.b)  n_ab10 <= n_ab10 + 1;
         if (!ifc.a && ifc.b)  n_ab01 <= n_ab01 + 1;
         if (ifc.busy)         n_busy <= n_busy + 1;
         if (ifc.done) begin
            n_done <= n_done + 1;
            if (nd < 8) begin
               dseq[nd] <= ifc.done_id;
               nd       <= nd + 1;
            end
         end
         wcyc <= wcyc + 1;
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic idle_inputs();
      ifc.req0_valid = 1'b0; ifc.req0_ab = 2'b00; ifc.req0_len = '0;
      ifc.req1_valid = 1'b0; ifc.req1_ab = 2'b00; ifc.req1_len = '0;
   endtask

   task automatic mon_start();
      wcyc = 0; n_r0 = 0; n_r1 = 0; first_r1 = -1; n_ab11 = 0; n_ab10 = 0; n_ab01 = 0;
      n_busy = 0; n_done = 0; ng = 0; nd = 0;
      mon_en = 1'b1;
   endtask

   task automatic do_reset();
      mon_en = 1'b0;
      idle_inputs();
      rstn = 1'b0;
      step(2);
      rstn = 1'b1;
   endtask

   initial begin
      idle_inputs();
      #1 rstn = 1'b0;
      #2;
      chk("rst_a",       ifc.a,       0);
      chk("rst_b",       ifc.b,       0);
      chk("rst_busy",    ifc.busy,    0);
      chk("rst_owner",   ifc.owner,   0);
      chk("rst_done",    ifc.done,    0);
      chk("rst_done_id", ifc.done_id, 0);
      chk_on = 1'b1;
      step(2);
      rstn = 1'b1;

      // single command: req0 {11, len 2}
      mon_start();
      ifc.req0_valid = 1'b1; ifc.req0_ab = 2'b11; ifc.req0_len = 3'd2;
      #1 chk("t1_ready0_now", ifc.req0_ready, 1);
      step(1);
      ifc.req0_valid = 1'b0;
      step(7);
      mon_en = 1'b0;
      chk("t1_ready0_cycles", n_r0,    1);
      chk("t1_ab11_cycles",   n_ab11,  3);
      chk("t1_busy_cycles",   n_busy,  4);
      chk("t1_done_pulses",   n_done,  1);
      chk("t1_done_id",       dseq[0], 0);

      // continuous contention: req0 {10,0}, req1 {01,1}
      do_reset();
      mon_start();
      ifc.req0_valid = 1'b1; ifc.req0_ab = 2'b10; ifc.req0_len = 3'd0;
      ifc.req1_valid = 1'b1; ifc.req1_ab = 2'b01; ifc.req1_len = 3'd1;
      step(14);
      idle_inputs();
      step(6);
      mon_en = 1'b0;
      chk("t2_grants",  ng, 4);
      chk("t2_grant0",  gseq[0], 0);
      chk("t2_grant1",  gseq[1], 1);
      chk("t2_grant2",  gseq[2], 0);
      chk("t2_grant3",  gseq[3], 1);
      chk("t2_dones",   nd, 4);
      chk("t2_doneid0", dseq[0], 0);
      chk("t2_doneid1", dseq[1], 1);
      chk("t2_doneid2", dseq[2], 0);
      chk("t2_doneid3", dseq[3], 1);
      chk("t2_ab10_cycles", n_ab10, 2);
      chk("t2_ab01_cycles", n_ab01, 4);

      // req1 arrives while req0 {01,3} runs
      do_reset();
      mon_start();
      ifc.req0_valid = 1'b1; ifc.req0_ab = 2'b01; ifc.req0_len = 3'd3;
      step(1);
      ifc.req0_valid = 1'b0;
      ifc.req1_valid = 1'b1; ifc.req1_ab = 2'b10; ifc.req1_len = 3'd0;
      step(6);
      ifc.req1_valid = 1'b0;
      step(5);
      mon_en = 1'b0;
      chk("t3_first_ready1", first_r1, 6);
      chk("t3_ready1_cycles", n_r1, 1);
      chk("t3_ready0_cycles", n_r0, 1);
      chk("t3_ab01_cycles", n_ab01, 4);
      chk("t3_ab10_cycles", n_ab10, 1);

      // maximum length: req1 {11,7}
      do_reset();
      mon_start();
      ifc.req1_valid = 1'b1; ifc.req1_ab = 2'b11; ifc.req1_len = 3'd7;
      step(1);
      ifc.req1_valid = 1'b0;
      step(12);
      mon_en = 1'b0;
      chk("t4_ab11_cycles", n_ab11, 8);
      chk("t4_busy_cycles", n_busy, 9);
      chk("t4_done_pulses", n_done, 1);
      chk("t4_done_id",     dseq[0], 1);

      // reset during the second RUN cycle of req0 {11,5}
      do_reset();
      mon_start();
      ifc.req0_valid = 1'b1; ifc.req0_ab = 2'b11; ifc.req0_len = 3'd5;
      step(1);
      ifc.req0_valid = 1'b0;
      step(1);
      #1 rstn = 1'b0;
      #1;
      chk("t5_a_async",    ifc.a,    0);
      chk("t5_b_async",    ifc.b,    0);
      chk("t5_busy_async", ifc.busy, 0);
      chk("t5_done_async", ifc.done, 0);
      step(1);
      ifc.req0_valid = 1'b1; ifc.req0_ab = 2'b01; ifc.req0_len = 3'd0;
      ifc.req1_valid = 1'b1; ifc.req1_ab = 2'b10; ifc.req1_len = 3'd0;
      rstn = 1'b1;
      #1;
      chk("t5_tie_ready0", ifc.req0_ready, 1);
      chk("t5_tie_ready1", ifc.req1_ready, 0);
      step(1);
      idle_inputs();
      step(8);
      mon_en = 1'b0;
      chk("t5_done_pulses", n_done, 1);
      chk("t5_done_id",     dseq[0], 0);
      chk("t5_ab11_cycles", n_ab11, 1);
      chk("t5_ab01_cycles", n_ab01, 1);

      // req0 valid only while req1 {11,3} runs
      do_reset();
      mon_start();
      ifc.req1_valid = 1'b1; ifc.req1_ab = 2'b11; ifc.req1_len = 3'd3;
      step(1);
      ifc.req1_valid = 1'b0;
      step(1);
      ifc.req0_valid = 1'b1; ifc.req0_ab = 2'b10; ifc.req0_len = 3'd1;
      step(1);
      ifc.req0_valid = 1'b0;
      step(8);
      mon_en = 1'b0;
      chk("t6_ready0_cycles", n_r0, 0);
      chk("t6_ready1_cycles", n_r1, 1);
      chk("t6_ab10_cycles",   n_ab10, 0);
      chk("t6_ab11_cycles",   n_ab11, 4);

      chk_on = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
